// File: rtl/ll_pkg.sv
// Shared types and BCD helpers for the lunar lander status controller.
package ll_pkg;

    typedef enum logic [1:0] {
        FLY     = 2'd0,
        LANDED  = 2'd1,
        CRASHED = 2'd2
    } ll_state_t;

    localparam int unsigned      DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] NEG_DIGIT = 4'd5;

    // 10's-complement sign: the most significant digit carries the sign.
    function automatic logic bcd_is_neg(input logic [DIGIT_W-1:0] ms_digit);
        return ms_digit >= NEG_DIGIT;
    endfunction

endpackage

// File: rtl/ll_status_fsm_if.sv
// Status controller bus: physics inputs in, status/display outputs out.
interface ll_status_fsm_if #(
    parameter int W = 16
);
    logic         tick;
    logic         restart;
    logic [W-1:0] alt;
    logic [W-1:0] vel;
    logic [W-1:0] thrust;
    logic [W-1:0] fuel;
    logic [1:0]   state;
    logic         land;
    logic         crash;
    logic         wen;
    logic         thrust_en;
    logic         fuel_out;
    logic [W-1:0] impact_vel;
    logic         blink;

    modport master (
        output tick, restart, alt, vel, thrust, fuel,
        input  state, land, crash, wen, thrust_en, fuel_out, impact_vel, blink
    );

    modport slave (
        input  tick, restart, alt, vel, thrust, fuel,
        output state, land, crash, wen, thrust_en, fuel_out, impact_vel, blink
    );

endinterface

// File: rtl/bcd_addsub_n.sv
// Ripple BCD adder/subtractor over DIGITS digits; op=1 computes a-b via 9's complement.
module bcd_addsub_n
    import ll_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      op,
    output logic [DIGIT_W*DIGITS-1:0] sum
);

    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W:0]   raw;
    logic               carry;

    // Carry out of the top digit is dropped, giving 10's-complement wrap.
    always_comb begin
        sum   = '0;
        b_dig = '0;
        raw   = '0;
        carry = op;
        for (int i = 0; i < DIGITS; i++) begin
            b_dig = op ? (4'd9 - b[i*DIGIT_W +: DIGIT_W]) : b[i*DIGIT_W +: DIGIT_W];
            raw   = {1'b0, a[i*DIGIT_W +: DIGIT_W]} + {1'b0, b_dig} + {4'b0000, carry};
            if (raw > 5'd9) begin
                sum[i*DIGIT_W +: DIGIT_W] = raw[DIGIT_W-1:0] + 4'd6;
                carry                     = 1'b1;
            end else begin
                sum[i*DIGIT_W +: DIGIT_W] = raw[DIGIT_W-1:0];
                carry                     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ll_status_fsm.sv
// Landing/crash status controller: evaluates touchdown once per tick, freezes
// the state memory in terminal states and supports restart without reset.
module ll_status_fsm
    import ll_pkg::*;
#(
    parameter int                    DIGITS     = 4,
    parameter logic [4*DIGITS-1:0]   SAFE_VEL   = 16'h9970,
    parameter logic [4*DIGITS-1:0]   MAX_THRUST = 16'h0005,
    parameter int                    CNT_W      = 8,
    parameter int                    BLINK_BIT  = 3
) (
    input  logic           clk,
    input  logic           rst,
    ll_status_fsm_if.slave bus
);

    localparam int W = DIGIT_W * DIGITS;

    ll_state_t         state_q, state_d;
    logic              wen_q, wen_d;
    logic              fuel_out_q, fuel_out_d;
    logic [W-1:0]      impact_vel_q, impact_vel_d;
    logic [CNT_W-1:0]  end_cnt_q, end_cnt_d;

    logic [W-1:0]      sum;
    logic              hit;
    logic              vel_too_fast;
    logic              thrust_too_high;
    logic              terminal;

    function automatic logic bcd_lt(input logic [W-1:0] a, input logic [W-1:0] b);
        logic a_neg;
        logic b_neg;
        a_neg = bcd_is_neg(a[W-1 -: DIGIT_W]);
        b_neg = bcd_is_neg(b[W-1 -: DIGIT_W]);
        if (a_neg != b_neg) return a_neg;
        return a < b;
    endfunction

    bcd_addsub_n #(.DIGITS(DIGITS)) u_alt_sum (
        .a   (bus.alt),
        .b   (bus.vel),
        .op  (1'b0),
        .sum (sum)
    );

    // Touching or below ground: altitude plus this tick's velocity reaches zero.
    assign hit             = (sum == '0) || bcd_is_neg(sum[W-1 -: DIGIT_W]);
    assign vel_too_fast    = bcd_lt(bus.vel, SAFE_VEL);
    assign thrust_too_high = bus.thrust > MAX_THRUST;
    assign terminal        = (state_q == LANDED) || (state_q == CRASHED);

    always_comb begin
        state_d      = state_q;
        fuel_out_d   = fuel_out_q;
        impact_vel_d = impact_vel_q;
        end_cnt_d    = end_cnt_q;

        case (state_q)
            FLY: begin
                if (bus.tick) begin
                    if (hit) begin
                        impact_vel_d = bus.vel;
                        state_d      = (vel_too_fast || thrust_too_high) ? CRASHED : LANDED;
                    end else if (bus.fuel == '0) begin
                        fuel_out_d = 1'b1;
                    end
                end
            end
            LANDED, CRASHED: begin
                if (bus.restart) begin
                    state_d      = FLY;
                    end_cnt_d    = '0;
                    fuel_out_d   = 1'b0;
                    impact_vel_d = '0;
                end else if (bus.tick && (end_cnt_q != {CNT_W{1'b1}})) begin
                    end_cnt_d = end_cnt_q + 1'b1;
                end
            end
            default: state_d = FLY;
        endcase

        wen_d = (state_d == FLY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FLY;
            wen_q        <= 1'b0;
            fuel_out_q   <= 1'b0;
            impact_vel_q <= '0;
            end_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            fuel_out_q   <= fuel_out_d;
            impact_vel_q <= impact_vel_d;
            end_cnt_q    <= end_cnt_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.land       = (state_q == LANDED);
    assign bus.crash      = (state_q == CRASHED);
    assign bus.wen        = wen_q;
    assign bus.thrust_en  = wen_q & ~fuel_out_q;
    assign bus.fuel_out   = fuel_out_q;
    assign bus.impact_vel = impact_vel_q;
    assign bus.blink      = terminal & end_cnt_q[BLINK_BIT];

endmodule

// File: tb/tb_ll_status_fsm.sv
// Scoreboard bench for ll_status_fsm: hand-derived expectations queued per cycle.
module tb_ll_status_fsm;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        wen;
        logic        te;
        logic        fo;
        logic        bl;
        logic [15:0] iv;
    } exp_t;

    exp_t sb_q[$];

    ll_status_fsm_if #(.W(16)) bus ();

    ll_status_fsm #(
        .DIGITS     (4),
        .SAFE_VEL   (16'h9970),
        .MAX_THRUST (16'h0005),
        .CNT_W      (8),
        .BLINK_BIT  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input exp_t e);
        chk({e.tag, ".state"},  {30'd0, bus.state},  {30'd0, e.st});
        chk({e.tag, ".land"},   {31'd0, bus.land},   {31'd0, (e.st == 2'd1)});
        chk({e.tag, ".crash"},  {31'd0, bus.crash},  {31'd0, (e.st == 2'd2)});
        chk({e.tag, ".wen"},    {31'd0, bus.wen},    {31'd0, e.wen});
        chk({e.tag, ".thr_en"}, {31'd0, bus.thrust_en}, {31'd0, e.te});
        chk({e.tag, ".fuel"},   {31'd0, bus.fuel_out}, {31'd0, e.fo});
        chk({e.tag, ".blink"},  {31'd0, bus.blink},  {31'd0, e.bl});
        chk({e.tag, ".impact"}, {16'd0, bus.impact_vel}, {16'd0, e.iv});
    endtask

    task automatic step(input string tag, input logic t, input logic r,
                        input logic [15:0] a, input logic [15:0] v,
                        input logic [15:0] th, input logic [15:0] f,
                        input logic [1:0] st, input logic wen, input logic te,
                        input logic fo, input logic bl, input logic [15:0] iv);
        exp_t e;
        @(negedge clk);
        bus.tick    = t;
        bus.restart = r;
        bus.alt     = a;
        bus.vel     = v;
        bus.thrust  = th;
        bus.fuel    = f;
        e.tag = tag; e.st = st; e.wen = wen; e.te = te; e.fo = fo; e.bl = bl; e.iv = iv;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            compare_out(sb_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst         = 1'b1;
        bus.tick    = 1'b0;
        bus.restart = 1'b0;
        bus.alt     = 16'h0500;
        bus.vel     = 16'h0000;
        bus.thrust  = 16'h0000;
        bus.fuel    = 16'h0100;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.state",  {30'd0, bus.state}, 32'd0);
        chk("reset.wen",    {31'd0, bus.wen}, 32'd0);
        chk("reset.thr_en", {31'd0, bus.thrust_en}, 32'd0);
        chk("reset.fuel",   {31'd0, bus.fuel_out}, 32'd0);
        chk("reset.impact", {16'd0, bus.impact_vel}, 32'd0);
        chk("reset.blink",  {31'd0, bus.blink}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //    tag                 t  r  alt      vel      thrust   fuel     st  wen te fo bl impact
        step("idle",             0, 0, 16'h0500, 16'h0000, 16'h0000, 16'h0100, 0, 1, 1, 0, 0, 16'h0000);
        step("near_miss",        1, 0, 16'h0050, 16'h9970, 16'h0000, 16'h0100, 0, 1, 1, 0, 0, 16'h0000);
        step("restart_in_fly",   0, 1, 16'h0050, 16'h9970, 16'h0000, 16'h0100, 0, 1, 1, 0, 0, 16'h0000);
        step("fuel_empty",       1, 0, 16'h0500, 16'h9990, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 16'h0000);
        step("fuel_sticky",      0, 0, 16'h0500, 16'h9990, 16'h0000, 16'h0100, 0, 1, 0, 1, 0, 16'h0000);
        step("safe_land",        1, 0, 16'h0020, 16'h9970, 16'h0005, 16'h0000, 1, 0, 0, 1, 0, 16'h9970);
        step("land_hold",        1, 0, 16'h0000, 16'h9000, 16'h0009, 16'h0000, 1, 0, 0, 1, 0, 16'h9970);
        step("restart_tick",     1, 1, 16'h0000, 16'h9960, 16'h0000, 16'h0100, 0, 1, 1, 0, 0, 16'h0000);
        step("zero_sum_land",    1, 0, 16'h0025, 16'h9975, 16'h0000, 16'h0100, 1, 0, 0, 0, 0, 16'h9975);
        step("restart2",         0, 1, 16'h0500, 16'h0000, 16'h0000, 16'h0100, 0, 1, 1, 0, 0, 16'h0000);
        step("vel_crash",        1, 0, 16'h0020, 16'h9960, 16'h0000, 16'h0100, 2, 0, 0, 0, 0, 16'h9960);
        for (int i = 1; i <= 7; i++) begin
            step("end_cnt",      1, 0, 16'h0500, 16'h0000, 16'h0000, 16'h0100, 2, 0, 0, 0, 0, 16'h9960);
        end
        step("end_cnt_notick",   0, 0, 16'h0500, 16'h0000, 16'h0000, 16'h0100, 2, 0, 0, 0, 0, 16'h9960);
        step("blink_on",         1, 0, 16'h0500, 16'h0000, 16'h0000, 16'h0100, 2, 0, 0, 0, 1, 16'h9960);
        step("restart3",         0, 1, 16'h0500, 16'h0000, 16'h0000, 16'h0100, 0, 1, 1, 0, 0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            step("tick_gated",   0, 0, 16'h0000, 16'h0000, 16'h0006, 16'h0100, 0, 1, 1, 0, 0, 16'h0000);
        end
        step("thrust_crash",     1, 0, 16'h0000, 16'h0000, 16'h0006, 16'h0100, 2, 0, 0, 0, 0, 16'h0000);

        @(negedge clk);
        bus.tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.crash", {31'd0, bus.crash}, 32'd0);
        chk("arst.wen",   {31'd0, bus.wen}, 32'd0);
        chk("arst.state", {30'd0, bus.state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_release.wen",   {31'd0, bus.wen}, 32'd1);
        chk("arst_release.state", {30'd0, bus.state}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ll_status_fsm.md
Name: ll_status_fsm

Overview:
- Parametrised landing/crash status controller for the lunar lander datapath.
- Evaluates BCD altitude, velocity and thrust once per game tick and decides between flying, safe landing and crash.
- Freezes the state memory through wen, latches the impact velocity, gates thrust when fuel is exhausted, and supports restart without a global reset.
- Sits between the physics registers (alt/vel/fuel) and the display/memory write path.

Parameters:
- DIGITS, 4: BCD digits per value; data width W = 4*DIGITS.
- SAFE_VEL, 16'h9970: minimum safe touchdown velocity (-30), 10's-complement BCD, W bits.
- MAX_THRUST, 16'h0005: maximum thrust allowed at touchdown, BCD, W bits.
- CNT_W, 8: width of the post-terminal tick counter.
- BLINK_BIT, 3: bit of the end counter driving blink.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tick  in  1  game-tick qualifier; evaluation only when high
- restart  in  1  single-cycle pulse; leaves a terminal state
- alt  in  W  altitude, 10's-complement BCD
- vel  in  W  velocity, 10's-complement BCD (negative = descending)
- thrust  in  W  commanded thrust, BCD, non-negative
- fuel  in  W  remaining fuel, BCD, non-negative
- state  out  2  FLY=0, LANDED=1, CRASHED=2 (3 unused)
- land  out  1  state==LANDED
- crash  out  1  state==CRASHED
- wen  out  1  memory write-enable
- thrust_en  out  1  thrust permitted
- fuel_out  out  1  sticky fuel-exhausted flag
- impact_vel  out  W  vel captured at touchdown
- blink  out  1  end_cnt[BLINK_BIT] in terminal states, else 0

Behaviour:
- Reset values: state=FLY, wen=0, fuel_out=0, impact_vel=0, end_cnt=0, so land=crash=blink=0. thrust_en=0 because wen=0.
- Sign rule: a value is negative iff its MS digit is >=5.
- Signed compare a<b:
  - signs differ: result = a negative.
  - signs equal: unsigned compare of the raw W-bit values.
- sum = alt + vel in W-bit BCD, 10's-complement wrap, carry out of the MS digit discarded.
- hit = (sum==0) or sum negative.
- FLY, tick=1, hit=1, then commit touchdown on this edge:
  - if vel<SAFE_VEL (signed) or thrust>MAX_THRUST (unsigned BCD), go to CRASHED; else go to LANDED.
  - impact_vel<=vel.
  - wen<=0 on the same edge.
- FLY, tick=1, hit=0: stay in FLY. If fuel==0, set fuel_out<=1.
- FLY, tick=0: hold all state. No evaluation and no fuel check.
- wen is registered: wen<=(next_state==FLY). Its first assertion is one cycle after rst is released.
- thrust_en = wen & ~fuel_out (combinational).
- LANDED/CRASHED:
  - state is frozen.
  - end_cnt increments on each tick and saturates at 2^CNT_W-1.
  - restart=1 → next state FLY; clear end_cnt, fuel_out and impact_vel; wen<=1.
- restart in FLY is ignored.
- restart and tick both high: restart wins and no evaluation happens that cycle.
- Terminal transitions occur only from FLY. LANDED↔CRASHED never occurs directly.
- An encoding of 3 in state recovers to FLY on the next edge.
- rst asserted mid-flight or mid-terminal: immediate return to reset values, independent of clk.
- Latency: status outputs change on the first clk edge where tick=1 and hit=1. Output is a pure state decode with no extra pipeline stage.

Decomposition:
- Package ll_pkg holds:
  - the state enum ll_state_t {FLY, LANDED, CRASHED};
  - DIGIT_W=4 and the negative-digit threshold 4'd5;
  - the function bcd_is_neg.
- One sub-module, bcd_addsub_n: a parametrised DIGITS-digit BCD adder/subtractor with op input. It is used for alt+vel.
- Comparators and the FSM stay in ll_status_fsm.

Test Plan:
- Near-miss: alt=0x0050, vel=0x9970, thrust=0, tick=1 → sum=0x0020, stays FLY, wen=1, land=crash=0.
- Safe landing at the boundary: alt=0x0020, vel=0x9970, thrust=0x0005, tick=1 → sum=0x9990; next edge land=1, wen=0, impact_vel=0x9970, state=1.
- Velocity crash: alt=0x0020, vel=0x9960, tick=1 → crash=1, wen=0, impact_vel=0x9960. Then hold for 8 ticks → blink=1 (end_cnt=8 with BLINK_BIT=3).
- Thrust crash and tick gating:
  - alt=0x0000, vel=0x0000, thrust=0x0006, tick=0 for 5 cycles → stays FLY.
  - Then tick=1 → crash=1.
- Fuel and restart:
  - fuel=0x0000, tick=1 in flight → fuel_out=1, thrust_en=0, state FLY.
  - After landing, restart=1 together with tick=1 → FLY next cycle, fuel_out=0, wen=1, impact_vel=0, no re-evaluation that cycle.
- Async reset mid-terminal: rst pulsed between clk edges while CRASHED → crash=0, wen=0 immediately. First edge after release → wen=1.
